// File: rtl/vga_pkg.sv
// Shared VGA constants and types for the timing generator and pixel fetch.
// Holds display geometry, porch timings, the pixel type and the fetch FSM states.
package vga_pkg;

    localparam int HDISP_DEF  = 800;
    localparam int VDISP_DEF  = 480;
    localparam int H_FP       = 40;
    localparam int H_SYNC     = 128;
    localparam int H_BP       = 88;
    localparam int V_FP       = 1;
    localparam int V_SYNC     = 4;
    localparam int V_BP       = 23;

    typedef logic [23:0] rgb_t;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        FLUSH,
        DONE
    } fetch_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; clear has priority over push and pop.
// Ports: clk, rst, push, pop, clear, din -> dout (0 when empty), empty, full, count.
module sync_fifo #(
    parameter  int WIDTH = 24,
    parameter  int DEPTH = 16,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count
);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;

    // A push into a full FIFO is fine when the head leaves in the same cycle:
    // the write lands in the slot being vacated.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem_q[wr_ptr_q] <= din;
    end

    assign dout = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/vga_pixel_fetch.sv
// Framebuffer pixel feeder: single-outstanding req/ack reads into a show-ahead FIFO.
// Ports: pixel_clk/pixel_rst, frame_start, pix_rd -> pix_data/pix_valid/underflow;
// memory side mem_req/mem_addr out, mem_rdata/mem_ack in.
module vga_pixel_fetch
    import vga_pkg::*;
#(
    parameter int              HDISP      = 800,
    parameter int              VDISP      = 480,
    parameter int              FIFO_DEPTH = 16,
    parameter int              AW         = 32,
    parameter logic [AW-1:0]   BASE_ADDR  = '0,
    parameter int              PIX_BYTES  = 4
) (
    input  logic          pixel_clk,
    input  logic          pixel_rst,
    input  logic          frame_start,
    input  logic          pix_rd,
    output logic [23:0]   pix_data,
    output logic          pix_valid,
    output logic          underflow,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic [31:0]   mem_rdata,
    input  logic          mem_ack
);

    localparam int TOTAL = HDISP * VDISP;
    localparam int FW    = $clog2(TOTAL + 1);
    localparam int CW    = $clog2(FIFO_DEPTH + 1);

    fetch_state_t  state_q, state_d;
    logic          mem_req_q, mem_req_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [FW-1:0] fetched_q, fetched_d;
    logic          underflow_q, underflow_d;

    logic          f_push;
    logic          f_pop;
    logic          f_clear;
    rgb_t          f_dout;
    logic          f_empty;
    logic          f_full;
    logic [CW-1:0] f_count;

    logic [CW:0]   inflight;
    logic          credit_ok;
    logic          more_ok;
    logic          restart;
    logic          unused_hi;

    assign unused_hi = &{1'b0, mem_rdata[31:24]};

    // The outstanding read already owns a FIFO slot.
    assign inflight  = {1'b0, f_count} + {{CW{1'b0}}, mem_req_q};
    assign credit_ok = inflight < (CW + 1)'(FIFO_DEPTH);
    assign more_ok   = fetched_q < FW'(TOTAL);

    // While flushing, a restart is already pending.
    assign restart = frame_start && (state_q != FLUSH);

    assign f_pop       = pix_rd && !f_empty && !frame_start;
    assign underflow_d = pix_rd && f_empty && !frame_start;

    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        fetched_d  = fetched_q;
        f_push     = 1'b0;
        f_clear    = 1'b0;
        if (restart) begin
            f_clear = 1'b1;
            if (mem_req_q && !mem_ack) begin
                // Cannot abandon a read mid-flight; wait it out.
                state_d = FLUSH;
            end else begin
                state_d    = FILL;
                mem_req_d  = 1'b0;
                mem_addr_d = BASE_ADDR;
                fetched_d  = '0;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                FILL: begin
                    if (mem_req_q) begin
                        if (mem_ack) begin
                            f_push     = 1'b1;
                            mem_req_d  = 1'b0;
                            mem_addr_d = mem_addr_q + AW'(PIX_BYTES);
                            fetched_d  = fetched_q + 1'b1;
                            if (fetched_q == FW'(TOTAL - 1)) state_d = DONE;
                        end
                    end else if (credit_ok && more_ok && !f_full) begin
                        mem_req_d = 1'b1;
                    end
                end
                FLUSH: begin
                    if (mem_ack) begin
                        state_d    = FILL;
                        mem_req_d  = 1'b0;
                        mem_addr_d = BASE_ADDR;
                        fetched_d  = '0;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (pixel_rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= BASE_ADDR;
            fetched_q   <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            fetched_q   <= fetched_d;
            underflow_q <= underflow_d;
        end
    end

    sync_fifo #(
        .WIDTH (24),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (pixel_clk),
        .rst   (pixel_rst),
        .push  (f_push),
        .pop   (f_pop),
        .clear (f_clear),
        .din   (mem_rdata[23:0]),
        .dout  (f_dout),
        .empty (f_empty),
        .full  (f_full),
        .count (f_count)
    );

    assign pix_data  = f_dout;
    assign pix_valid = !f_empty;
    assign underflow = underflow_q;
    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Scoreboard bench for vga_pixel_fetch with a small framebuffer.
// Memory model acks after a programmable wait; expected pixels queued per frame.
module tb_vga_pixel_fetch;

    localparam int          HD    = 8;
    localparam int          VD    = 4;
    localparam int          DEP   = 16;
    localparam int          TOTAL = HD * VD;
    localparam int          PIXB  = 4;
    localparam logic [31:0] BASE  = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        pixel_rst;
    logic        frame_start;
    logic        pix_rd;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic        underflow;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    always #5 clk = ~clk;

    vga_pixel_fetch #(
        .HDISP      (HD),
        .VDISP      (VD),
        .FIFO_DEPTH (DEP),
        .AW         (32),
        .BASE_ADDR  (BASE),
        .PIX_BYTES  (PIXB)
    ) dut (
        .pixel_clk   (clk),
        .pixel_rst   (pixel_rst),
        .frame_start (frame_start),
        .pix_rd      (pix_rd),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .underflow   (underflow),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack)
    );

    int          n_tot = 0;
    int          n_bad = 0;
    int          ack_cnt = 0;
    int          ack_lat = 0;
    int          wait_cnt = 0;
    int          uf_cnt = 0;
    bit          ack_hold = 1'b0;
    bit          addr_chk = 1'b0;
    logic [31:0] exp_addr = BASE;
    logic [23:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] a);
        logic [31:0] h;
        h = a * 32'h9E37_79B1;
        return {8'hC3, h[31:8]};
    endfunction

    task automatic load_frame();
        logic [31:0] w;
        exp_q.delete();
        for (int i = 0; i < TOTAL; i++) begin
            w = word_of(BASE + 32'(i * PIXB));
            exp_q.push_back(w[23:0]);
        end
        exp_addr = BASE;
    endtask

    // One clock: memory answers, scoreboard pops, then step to next negedge.
    task automatic tick();
        logic [23:0] e;
        mem_ack   = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;
        if (mem_req === 1'b1 && !ack_hold) begin
            if (wait_cnt >= ack_lat) begin
                mem_ack   = 1'b1;
                mem_rdata = word_of(mem_addr);
                wait_cnt  = 0;
                ack_cnt++;
                if (addr_chk) begin
                    chk("addr_seq", mem_addr, exp_addr);
                    exp_addr = exp_addr + PIXB;
                end
            end else begin
                wait_cnt++;
            end
        end else if (mem_req !== 1'b1) begin
            wait_cnt = 0;
        end
        if (pix_rd && pix_valid === 1'b1 && !frame_start) begin
            chk("sb_avail", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pix_order", 32'(pix_data), 32'(e));
            end
        end
        if (frame_start) load_frame();
        @(negedge clk);
        if (underflow === 1'b1) uf_cnt++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int a0;
        int pops;
        bit seen;
        logic [31:0] held;

        pixel_rst   = 1'b1;
        frame_start = 1'b0;
        pix_rd      = 1'b0;
        mem_ack     = 1'b0;
        mem_rdata   = '0;
        @(negedge clk);
        tick();
        tick();
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_addr", mem_addr, BASE);
        chk("rst_valid", 32'(pix_valid), 32'd0);
        chk("rst_data", 32'(pix_data), 32'd0);
        chk("rst_uf", 32'(underflow), 32'd0);
        pixel_rst = 1'b0;
        tick();

        // Underflow on empty FIFO
        pix_rd = 1'b1;
        tick();
        pix_rd = 1'b0;
        chk("uf_pulse", 32'(underflow), 32'd1);
        chk("uf_data", 32'(pix_data), 32'd0);
        chk("uf_valid", 32'(pix_valid), 32'd0);
        tick();
        chk("uf_one_cycle", 32'(underflow), 32'd0);
        chk("idle_no_req", 32'(mem_req), 32'd0);

        // Fill to depth, addresses in order, request stops when full
        addr_chk    = 1'b1;
        frame_start = 1'b1;
        a0          = ack_cnt;
        tick();
        frame_start = 1'b0;
        repeat (40) tick();
        addr_chk = 1'b0;
        chk("fill_acks", 32'(ack_cnt - a0), 32'(DEP));
        chk("fill_valid", 32'(pix_valid), 32'd1);
        chk("fill_head", 32'(pix_data), 32'(exp_q[0]));
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (mem_req) seen = 1'b1;
        end
        chk("full_req_low", 32'(seen), 32'd0);

        // Push and pop in the same cycle near full
        pix_rd = 1'b1;
        tick();
        pix_rd = 1'b0;
        n = 0;
        while (mem_req !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        chk("credit_req", 32'(mem_req), 32'd1);
        a0     = ack_cnt;
        pix_rd = 1'b1;
        tick();
        pix_rd   = 1'b0;
        ack_hold = 1'b1;
        chk("pushpop_ack", 32'(ack_cnt - a0), 32'd1);
        pops = 0;
        n    = 0;
        while (pix_valid === 1'b1 && n < 40) begin
            pix_rd = 1'b1;
            tick();
            pops++;
            n++;
        end
        pix_rd = 1'b0;
        chk("pushpop_count", 32'(pops), 32'd15);
        chk("pending_req", 32'(mem_req), 32'd1);

        // Restart while a read is outstanding
        held        = mem_addr;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        ack_hold    = 1'b0;
        ack_lat     = 5;
        wait_cnt    = 0;
        repeat (3) tick();
        chk("flush_req_held", 32'(mem_req), 32'd1);
        chk("flush_addr_held", mem_addr, held);
        a0 = ack_cnt;
        n  = 0;
        while (ack_cnt == a0 && n < 20) begin
            tick();
            n++;
        end
        chk("flush_ack_seen", 32'(ack_cnt - a0), 32'd1);
        ack_lat = 0;
        chk("flush_dropped", 32'(pix_valid), 32'd0);
        tick();
        chk("flush_new_req", 32'(mem_req), 32'd1);
        chk("flush_base", mem_addr, BASE);

        // Whole frame at 50% display duty after a blanking prefill
        repeat (40) tick();
        uf_cnt = 0;
        for (int l = 0; l < VD; l++) begin
            for (int c = 0; c < 2 * HD; c++) begin
                pix_rd = (c < HD);
                tick();
            end
        end
        pix_rd = 1'b0;
        chk("frame_drained", 32'(exp_q.size()), 32'd0);
        chk("frame_no_uf", 32'(uf_cnt), 32'd0);
        chk("frame_empty", 32'(pix_valid), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (mem_req) seen = 1'b1;
        end
        chk("done_no_req", 32'(seen), 32'd0);

        // Restart coincident with an ack and a pop request
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        a0 = ack_cnt;
        n  = 0;
        while (ack_cnt - a0 < 5 && n < 50) begin
            tick();
            n++;
        end
        n = 0;
        while (mem_req !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        chk("coinc_req_up", 32'(mem_req), 32'd1);
        a0          = ack_cnt;
        uf_cnt      = 0;
        frame_start = 1'b1;
        pix_rd      = 1'b1;
        tick();
        frame_start = 1'b0;
        pix_rd      = 1'b0;
        chk("coinc_ack", 32'(ack_cnt - a0), 32'd1);
        chk("coinc_empty", 32'(pix_valid), 32'd0);
        chk("coinc_data0", 32'(pix_data), 32'd0);
        chk("coinc_base", mem_addr, BASE);
        chk("coinc_req_low", 32'(mem_req), 32'd0);
        chk("coinc_no_uf", 32'(uf_cnt), 32'd0);
        pops = 0;
        for (int i = 0; i < 60; i++) begin
            pix_rd = pix_valid;
            if (pix_valid) pops++;
            tick();
        end
        pix_rd = 1'b0;
        chk("coinc_stream", 32'(pops > 10), 32'd1);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
